// File: rtl/seq_divider_pkg.sv
// Shared types, default widths and sizing helper for the sequential divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DEF_N_WIDTH = 32;
    localparam int DEF_D_WIDTH = 16;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH
) (
    input  logic [D_WIDTH:0]   rem,
    input  logic               next_bit,
    input  logic [D_WIDTH-1:0] divisor,
    output logic [D_WIDTH:0]   rem_next,
    output logic               q_bit
);

    logic [D_WIDTH+1:0] shifted;
    logic [D_WIDTH+1:0] wide_div;

    always_comb begin
        shifted  = {rem, next_bit};
        wide_div = {2'b00, divisor};
        q_bit    = (shifted >= wide_div);
        // After a successful subtract the result is below divisor, so it fits
        rem_next = q_bit ? (D_WIDTH+1)'(shifted - wide_div)
                         : shifted[D_WIDTH:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_FORMAL_EN to compile in the checking assertions.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N_WIDTH = DEF_N_WIDTH,
    parameter int D_WIDTH = DEF_D_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_WIDTH-1:0] dividend,
    input  logic [D_WIDTH-1:0] divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_WIDTH-1:0] quotient,
    output logic [D_WIDTH-1:0] remainder,
    output logic               div_by_zero
);

    localparam int CNT_W = clog2(N_WIDTH);

    div_state_e         state;
    logic [D_WIDTH:0]   rem;
    logic [N_WIDTH-1:0] quo;
    logic [D_WIDTH-1:0] dsr;
    logic [CNT_W-1:0]   cnt;
    logic [D_WIDTH:0]   rem_nxt;
    logic               q_bit;
    logic [N_WIDTH-1:0] quo_nxt;

    div_step #(
        .D_WIDTH (D_WIDTH)
    ) u_step (
        .rem      (rem),
        .next_bit (quo[N_WIDTH-1]),
        .divisor  (dsr),
        .rem_next (rem_nxt),
        .q_bit    (q_bit)
    );

    // quo doubles as the dividend shift register: MSB out, quotient bit in
    assign quo_nxt = {quo[N_WIDTH-2:0], q_bit};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            dsr         <= '0;
            cnt         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        dsr      <= divisor;
                        if (divisor == '0) begin
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend[D_WIDTH-1:0];
                            div_by_zero <= 1'b1;
                        end else begin
                            rem   <= '0;
                            quo   <= dividend;
                            cnt   <= CNT_W'(N_WIDTH - 1);
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        quotient    <= quo_nxt;
                        remainder   <= rem_nxt[D_WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_DIVIDER_FORMAL_EN
    localparam int P_W = N_WIDTH + D_WIDTH;

    logic [N_WIDTH-1:0] dividend_q;
    logic [N_WIDTH-1:0] quotient_q;
    logic [D_WIDTH-1:0] remainder_q;
    logic               dbz_q;
    logic               hold_q;
    logic               in_valid_q;
    logic               in_ready_q;
    logic [P_W-1:0]     product;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dividend_q  <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            hold_q      <= 1'b0;
            in_valid_q  <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                dividend_q <= dividend;
            end
            quotient_q  <= quotient;
            remainder_q <= remainder;
            dbz_q       <= div_by_zero;
            hold_q      <= out_valid && !out_ready;
            in_valid_q  <= in_valid;
            in_ready_q  <= in_ready;
        end
    end

    assign product = P_W'(quotient) * P_W'(dsr) + P_W'(remainder);

    always @(posedge clk) begin
        if (rst_n) begin
            if (out_valid && !div_by_zero) begin
                assert (product == P_W'(dividend_q));
                assert (remainder < dsr);
            end
            if (hold_q) begin
                assert (out_valid);
                assert (quotient == quotient_q);
                assert (remainder == remainder_q);
                assert (div_by_zero == dbz_q);
            end
            assert (!(in_ready && out_valid));
            if (in_valid_q && !in_ready_q) begin
                assume (in_valid);
            end
        end
    end
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Directed vector bench for seq_divider with handshake and reset corner cases.
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [31:0] n;
        logic [15:0] d;
        logic [31:0] q;
        logic [15:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    seq_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ends at the negedge just after the accepting posedge
    task automatic start_op(input logic [31:0] n, input logic [15:0] d);
        int guard;
        guard    = 0;
        dividend = n;
        divisor  = d;
        in_valid = 1'b1;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Latency counts edges from accept to the first edge seeing out_valid
    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_op;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("post_hs_out_valid", 64'(out_valid), 64'd0);
        check("post_hs_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        logic [31:0] q_hold;

        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        vecs[0] = '{32'h0038FC70, 16'h0072, 32'h00007FF8, 16'h0000, 1'b0, 33};
        vecs[1] = '{32'h0038FC75, 16'h0072, 32'h00007FF8, 16'h0005, 1'b0, 33};
        vecs[2] = '{32'h00001234, 16'h0000, 32'hFFFFFFFF, 16'h1234, 1'b1, 1};
        vecs[3] = '{32'hFFFFFFFF, 16'h0001, 32'hFFFFFFFF, 16'h0000, 1'b0, 33};
        vecs[4] = '{32'hFFFFFFFF, 16'hFFFF, 32'h00010001, 16'h0000, 1'b0, 33};
        vecs[5] = '{32'd100,      16'd7,    32'd14,       16'd2,    1'b0, 33};
        vecs[6] = '{32'd0,        16'd5,    32'd0,        16'd0,    1'b0, 33};
        vecs[7] = '{32'd7,        16'd9,    32'd0,        16'd7,    1'b0, 33};
        vecs[8] = '{32'hFFFFFFFF, 16'h0000, 32'hFFFFFFFF, 16'hFFFF, 1'b1, 1};
        vecs[9] = '{32'h80000000, 16'd3,    32'h2AAAAAAA, 16'd2,    1'b0, 33};

        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_quotient", 64'(quotient), 64'd0);
        check("rst_remainder", 64'(remainder), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].n, vecs[i].d);
            wait_result(lat);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d_quotient", i), 64'(quotient), 64'(vecs[i].q));
            check($sformatf("v%0d_remainder", i), 64'(remainder), 64'(vecs[i].r));
            check($sformatf("v%0d_dbz", i), 64'(div_by_zero), 64'(vecs[i].dz));
            finish_op();
        end

        // Backpressure: result held, new request ignored until handshake
        start_op(32'd100, 16'd7);
        wait_result(lat);
        check("bp_first_latency", 64'(lat), 64'd33);
        q_hold   = quotient;
        dividend = 32'd50;
        divisor  = 16'd5;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_quotient", 64'(quotient), 64'd14);
            check("bp_remainder", 64'(remainder), 64'd2);
            check("bp_q_stable", 64'(quotient), 64'(q_hold));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_hs_out_valid", 64'(out_valid), 64'd0);
        check("bp_hs_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_accepted", 64'(in_ready), 64'd0);
        wait_result(lat);
        check("bp_second_latency", 64'(lat), 64'd33);
        check("bp_second_quotient", 64'(quotient), 64'd10);
        check("bp_second_remainder", 64'(remainder), 64'd0);
        finish_op();

        // Reset in the middle of BUSY aborts without a result
        start_op(32'h0038FC70, 16'h0072);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_quotient", 64'(quotient), 64'd0);
        check("mid_rst_remainder", 64'(remainder), 64'd0);
        @(negedge clk);
        check("mid_rel_in_ready", 64'(in_ready), 64'd1);
        check("mid_rel_out_valid", 64'(out_valid), 64'd0);
        repeat (40) begin
            @(negedge clk);
            if (out_valid) begin
                check("mid_rst_stray_result", 64'(out_valid), 64'd0);
            end
        end
        start_op(32'd100, 16'd7);
        wait_result(lat);
        check("after_rst_latency", 64'(lat), 64'd33);
        check("after_rst_quotient", 64'(quotient), 64'd14);
        check("after_rst_remainder", 64'(remainder), 64'd2);
        check("after_rst_dbz", 64'(div_by_zero), 64'd0);
        finish_op();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
